// File: rtl/qkd_bram_pkg.sv
// Encodings, addresses and responder state type shared by both sides of the
// manager BRAM state-word handshake.
package qkd_bram_pkg;

    localparam logic [3:0] ON_STATE      = 4'h1;
    localparam logic [3:0] OFF_STATE     = 4'h0;
    localparam logic [3:0] IDLE_STATE    = 4'h0;
    localparam logic [3:0] REQUEST_STATE = 4'h1;
    localparam logic [3:0] READY_STATE   = 4'h2;

    localparam logic [3:0] WRITER_PC     = 4'hA;
    localparam logic [3:0] WRITER_KCU116 = 4'hB;

    localparam logic [31:0] PC_STATE_ADDRESS   = 32'h0;
    localparam logic [31:0] FPGA_STATE_ADDRESS = 32'h8;

    localparam int NO_USE_BIT_WIDTH = 32;
    localparam logic [1:0] SETTLE_CYCLES = 2'd2;

    typedef enum logic [3:0] {
        RSP_OFF         = 4'd0,
        RSP_WRITE_ON    = 4'd1,
        RSP_POLL_REQ    = 4'd2,
        RSP_SERVICE     = 4'd3,
        RSP_WRITE_READY = 4'd4,
        RSP_POLL_IDLE   = 4'd5,
        RSP_WRITE_IDLE  = 4'd6,
        RSP_WRITE_OFF   = 4'd7
    } rsp_state_e;

    // All six service fields carry the same code in every word the host writes.
    function automatic logic [63:0] make_state_word(input logic [3:0] onoff,
                                                    input logic [3:0] field,
                                                    input logic [3:0] writer);
        return {{NO_USE_BIT_WIDTH{1'b0}}, onoff, {6{field}}, writer};
    endfunction

endpackage

// File: rtl/a_bram_host_responder_fsm.sv
// Round sequencing for the host responder: state register, next-state logic
// and the read settle counter that masks stale data on entry to a poll state.
module a_bram_host_responder_fsm
    import qkd_bram_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       qkd_enable,
    input  logic       service_done,
    input  logic       req_hit,
    input  logic       idle_hit,
    output rsp_state_e state,
    output logic       settled,
    output logic       take_req
);

    rsp_state_e state_q, state_d;
    logic [1:0] settle_q, settle_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RSP_OFF;
            settle_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RSP_OFF:         if (qkd_enable) state_d = RSP_WRITE_ON;
            RSP_WRITE_ON:    state_d = qkd_enable ? RSP_POLL_REQ : RSP_WRITE_OFF;
            RSP_POLL_REQ: begin
                if (!qkd_enable)            state_d = RSP_WRITE_OFF;
                else if (settled && req_hit) state_d = RSP_SERVICE;
            end
            // A drop of qkd_enable is held off until the stub finishes.
            RSP_SERVICE:     if (service_done) state_d = qkd_enable ? RSP_WRITE_READY : RSP_WRITE_OFF;
            RSP_WRITE_READY: state_d = qkd_enable ? RSP_POLL_IDLE : RSP_WRITE_OFF;
            RSP_POLL_IDLE: begin
                if (!qkd_enable)             state_d = RSP_WRITE_OFF;
                else if (settled && idle_hit) state_d = RSP_WRITE_IDLE;
            end
            RSP_WRITE_IDLE:  state_d = qkd_enable ? RSP_POLL_REQ : RSP_WRITE_OFF;
            RSP_WRITE_OFF:   state_d = RSP_OFF;
            default:         state_d = RSP_OFF;
        endcase

        settle_d = settle_q;
        if ((state_d == RSP_POLL_REQ || state_d == RSP_POLL_IDLE) && state_d != state_q)
            settle_d = SETTLE_CYCLES;
        else if (settle_q != 2'd0)
            settle_d = settle_q - 2'd1;
    end

    always_comb begin
        state    = state_q;
        settled  = (settle_q == 2'd0);
        take_req = (state_q == RSP_POLL_REQ) && (state_d == RSP_SERVICE);
    end

endmodule

// File: rtl/a_bram_host_responder.sv
// Host-side responder on BRAM port A: announces ON, services FPGA requests via
// the local stub, acknowledges with READY and closes each round with IDLE.
module a_bram_host_responder
    import qkd_bram_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        qkd_enable,
    output logic        service_req,
    output logic [5:0]  service_fields,
    input  logic        service_done,
    output logic        bram_clka,
    output logic [31:0] bram_addra,
    output logic [63:0] bram_dina,
    output logic        bram_ena,
    output logic        bram_rsta,
    output logic [7:0]  bram_wea,
    input  logic [63:0] bram_douta,
    output logic [15:0] round_count,
    output logic        protocol_error,
    output logic [3:0]  responder_state
);

    rsp_state_e state;
    logic       settled, take_req;

    logic [63:0] dout_q, dout_d;
    logic [5:0]  service_fields_q, service_fields_d;
    logic [15:0] round_count_q, round_count_d;
    logic        protocol_error_q, protocol_error_d;

    logic [5:0] req_bits;
    logic       bad_field, live_word, req_hit, illegal_hit, idle_hit;

    a_bram_host_responder_fsm u_fsm (
        .clk          (clk),
        .rst          (rst),
        .qkd_enable   (qkd_enable),
        .service_done (service_done),
        .req_hit      (req_hit),
        .idle_hit     (idle_hit),
        .state        (state),
        .settled      (settled),
        .take_req     (take_req)
    );

    // Field i sits at bits [4i+7:4i+4]: i = 0 is sk2, i = 5 is sklen.
    always_comb begin
        req_bits  = 6'd0;
        bad_field = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_bits[i] = (dout_q[4*i+4 +: 4] == REQUEST_STATE);
            if (dout_q[4*i+4 +: 4] != IDLE_STATE && dout_q[4*i+4 +: 4] != REQUEST_STATE)
                bad_field = 1'b1;
        end
        live_word   = (dout_q[31:28] == ON_STATE) && (dout_q[3:0] == WRITER_KCU116);
        req_hit     = live_word && !bad_field && (req_bits != 6'd0);
        illegal_hit = live_word && bad_field;
        idle_hit    = (dout_q == make_state_word(ON_STATE, IDLE_STATE, WRITER_KCU116));
    end

    always_comb begin
        dout_d           = bram_douta;
        service_fields_d = take_req ? req_bits : service_fields_q;
        round_count_d    = round_count_q;
        if (state == RSP_WRITE_IDLE)
            round_count_d = round_count_q + 16'd1;
        protocol_error_d = protocol_error_q
                         | ((state == RSP_POLL_REQ) && settled && illegal_hit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q           <= 64'h0;
            service_fields_q <= 6'd0;
            round_count_q    <= 16'd0;
            protocol_error_q <= 1'b0;
        end else begin
            dout_q           <= dout_d;
            service_fields_q <= service_fields_d;
            round_count_q    <= round_count_d;
            protocol_error_q <= protocol_error_d;
        end
    end

    always_comb begin
        bram_wea   = 8'h00;
        bram_dina  = 64'h0;
        bram_addra = FPGA_STATE_ADDRESS;
        case (state)
            RSP_WRITE_ON, RSP_WRITE_IDLE: begin
                bram_wea   = 8'hFF;
                bram_addra = PC_STATE_ADDRESS;
                bram_dina  = make_state_word(ON_STATE, IDLE_STATE, WRITER_PC);
            end
            RSP_WRITE_READY: begin
                bram_wea   = 8'hFF;
                bram_addra = PC_STATE_ADDRESS;
                bram_dina  = make_state_word(ON_STATE, READY_STATE, WRITER_PC);
            end
            RSP_WRITE_OFF: begin
                bram_wea   = 8'hFF;
                bram_addra = PC_STATE_ADDRESS;
            end
            default: ;
        endcase
    end

    assign bram_clka       = clk;
    assign bram_ena        = 1'b1;
    assign bram_rsta       = 1'b0;
    assign service_req     = (state == RSP_SERVICE);
    assign service_fields  = service_fields_q;
    assign round_count     = round_count_q;
    assign protocol_error  = protocol_error_q;
    assign responder_state = state;

endmodule

// File: tb/tb_a_bram_host_responder.sv
// Bench for a_bram_host_responder: a dual-port BRAM model with the FPGA side
// driven by directed tasks, and a queue of expected port-A writes.
module tb_a_bram_host_responder;

    localparam logic [63:0] W_ON    = 64'h0000_0000_1000_000A;
    localparam logic [63:0] W_READY = 64'h0000_0000_1222_222A;
    localparam logic [63:0] W_OFF   = 64'h0;
    localparam logic [63:0] F_IDLE  = 64'h0000_0000_1000_000B;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        qkd_enable = 1'b0;
    logic        service_done = 1'b0;
    logic        service_req;
    logic [5:0]  service_fields;
    logic        bram_clka;
    logic [31:0] bram_addra;
    logic [63:0] bram_dina;
    logic        bram_ena;
    logic        bram_rsta;
    logic [7:0]  bram_wea;
    logic [63:0] bram_douta = 64'h0;
    logic [15:0] round_count;
    logic        protocol_error;
    logic [3:0]  responder_state;

    logic        b_we = 1'b0;
    logic [63:0] b_din = 64'h0;
    logic [63:0] mem [0:1] = '{64'h0, 64'h0};

    logic [103:0] exp_q[$];
    logic [103:0] obs_q[$];

    int n_total = 0;
    int n_pass  = 0;
    logic [15:0] model_rounds = 16'd0;
    logic        model_perr   = 1'b0;

    a_bram_host_responder dut (
        .clk             (clk),
        .rst             (rst),
        .qkd_enable      (qkd_enable),
        .service_req     (service_req),
        .service_fields  (service_fields),
        .service_done    (service_done),
        .bram_clka       (bram_clka),
        .bram_addra      (bram_addra),
        .bram_dina       (bram_dina),
        .bram_ena        (bram_ena),
        .bram_rsta       (bram_rsta),
        .bram_wea        (bram_wea),
        .bram_douta      (bram_douta),
        .round_count     (round_count),
        .protocol_error  (protocol_error),
        .responder_state (responder_state)
    );

    always #5 clk = ~clk;

    // Word 0 is the PC state word (0x0), word 1 the FPGA state word (0x8).
    always @(posedge clk) begin
        if (bram_wea != 8'h00) mem[bram_addra[3]] <= bram_dina;
        if (b_we) mem[1] <= b_din;
        bram_douta <= mem[bram_addra[3]];
    end

    always @(negedge clk) begin
        if (bram_wea !== 8'h00) obs_q.push_back({bram_wea, bram_addra, bram_dina});
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [103:0] obs, input logic [103:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_write(input logic [31:0] addr, input logic [63:0] data);
        exp_q.push_back({8'hFF, addr, data});
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_write_count"}, 104'(obs_q.size()), 104'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "_write"}, obs_q.pop_front(), exp_q.pop_front());
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic fpga_write(input logic [63:0] w);
        @(negedge clk);
        b_we  = 1'b1;
        b_din = w;
        @(negedge clk);
        b_we  = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        service_done = 1'b1;
        @(negedge clk);
        service_done = 1'b0;
    endtask

    task automatic wait_state(input string tag, input logic [3:0] st, input int budget);
        int k = 0;
        while (responder_state !== st && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, responder_state, st);
    endtask

    // 0 = ignored, 1 = request, 2 = illegal field in a live FPGA word.
    function automatic int classify(input logic [63:0] w);
        int any_req = 0;
        int bad = 0;
        if (((w >> 28) & 64'hF) != 64'h1 || (w & 64'hF) != 64'hB) return 0;
        for (int i = 1; i <= 6; i++) begin
            int f = int'((w >> (4*i)) & 64'hF);
            if (f == 1) any_req = 1;
            else if (f != 0) bad = 1;
        end
        if (bad != 0) return 2;
        return any_req;
    endfunction

    function automatic logic [63:0] req_word(input logic [5:0] mask);
        logic [63:0] w = F_IDLE;
        for (int i = 0; i < 6; i++)
            if (mask[i]) w = w + (64'h1 << (4 + 4*i));
        return w;
    endfunction

    task automatic send_nonreq(input string tag, input logic [63:0] w);
        fpga_write(w);
        tick(5);
        if (classify(w) == 2) model_perr = 1'b1;
        chk({tag, "_state"}, responder_state, 4'd2);
        chk({tag, "_service_req"}, service_req, 1'b0);
        chk({tag, "_perr"}, protocol_error, model_perr);
    endtask

    task automatic do_round(input logic [5:0] mask, input int delay, input bit noise);
        if (noise) begin
            if ($urandom_range(0, 1) == 1)
                send_nonreq("noise_writer", {32'h0, 4'h1, 24'($urandom), 4'($urandom_range(0, 9))});
            else
                send_nonreq("noise_off", {32'h0, 4'($urandom_range(2, 15)), 24'($urandom), 4'hB});
            pulse_done();
            tick(1);
            chk("stray_done_state", responder_state, 4'd2);
        end
        fpga_write(req_word(mask));
        tick(2);
        chk("req_latency_low", service_req, 1'b0);
        tick(1);
        chk("req_latency_high", service_req, 1'b1);
        chk("service_fields", service_fields, mask);
        tick(delay);
        chk("service_held", service_req, 1'b1);
        pulse_done();
        chk("write_ready_state", responder_state, 4'd4);
        exp_write(32'h0, W_READY);
        tick(1);
        chk("poll_idle_state", responder_state, 4'd5);
        fpga_write(F_IDLE);
        tick(2);
        chk("poll_idle_wait", responder_state, 4'd5);
        tick(1);
        chk("write_idle_state", responder_state, 4'd6);
        exp_write(32'h0, W_ON);
        model_rounds = model_rounds + 16'd1;
        tick(1);
        chk("round_count", round_count, model_rounds);
        chk("back_to_poll", responder_state, 4'd2);
        chk("fields_hold", service_fields, mask);
        chk("perr_round", protocol_error, model_perr);
        check_writes("round");
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"}, responder_state, 4'd0);
        chk({tag, "_service_req"}, service_req, 1'b0);
        chk({tag, "_fields"}, service_fields, 6'd0);
        chk({tag, "_rounds"}, round_count, 16'd0);
        chk({tag, "_perr"}, protocol_error, 1'b0);
        chk({tag, "_wea"}, bram_wea, 8'h00);
        chk({tag, "_dina"}, bram_dina, 64'h0);
        chk({tag, "_addra"}, bram_addra, 32'h8);
    endtask

    initial begin
        logic [5:0] m;

        // Reset and idle with the session off.
        tick(3);
        check_reset_outputs("reset");
        chk("ena", bram_ena, 1'b1);
        chk("rsta", bram_rsta, 1'b0);
        rst = 1'b0;
        tick(4);
        chk("off_idle_state", responder_state, 4'd0);
        check_writes("off_idle");

        // Session start: ON word, then polling of the FPGA word.
        qkd_enable = 1'b1;
        tick(1);
        chk("write_on_state", responder_state, 4'd1);
        chk("write_on_wea", bram_wea, 8'hFF);
        chk("write_on_addr", bram_addra, 32'h0);
        chk("write_on_data", bram_dina, W_ON);
        exp_write(32'h0, W_ON);
        tick(1);
        chk("poll_state", responder_state, 4'd2);
        chk("poll_wea", bram_wea, 8'h00);
        chk("poll_addr", bram_addra, 32'h8);
        check_writes("start");

        // Directed round from the test plan, then randomized rounds.
        do_round(6'b011000, 1, 1'b0);
        for (int r = 0; r < 3; r++) begin
            m = 6'($urandom_range(1, 63));
            do_round(m, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        // Illegal field code: flag set, word ignored, flag sticky afterwards.
        send_nonreq("illegal", 64'h0000_0000_1031_000B);
        for (int r = 0; r < 2; r++) begin
            m = 6'($urandom_range(1, 63));
            do_round(m, $urandom_range(0, 3), 1'b1);
        end

        // Round counter wrap.
        @(negedge clk);
        force dut.round_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.round_count_q;
        model_rounds = 16'hFFFF;
        tick(1);
        chk("preload_rounds", round_count, 16'hFFFF);
        do_round(6'($urandom_range(1, 63)), 0, 1'b0);

        // qkd_enable dropped during SERVICE waits for service_done.
        m = 6'($urandom_range(1, 63));
        fpga_write(req_word(m));
        tick(3);
        chk("svc_before_drop", service_req, 1'b1);
        qkd_enable = 1'b0;
        tick(3);
        chk("svc_deferred_state", responder_state, 4'd3);
        check_writes("svc_deferred");
        pulse_done();
        chk("write_off_state", responder_state, 4'd7);
        chk("write_off_wea", bram_wea, 8'hFF);
        chk("write_off_addr", bram_addra, 32'h0);
        chk("write_off_data", bram_dina, W_OFF);
        exp_write(32'h0, W_OFF);
        tick(1);
        chk("off_after_drop", responder_state, 4'd0);
        chk("off_wea", bram_wea, 8'h00);
        tick(2);
        check_writes("drop");

        // Asynchronous reset while waiting in POLL_IDLE.
        qkd_enable = 1'b1;
        tick(1);
        chk("rewrite_on_state", responder_state, 4'd1);
        exp_write(32'h0, W_ON);
        wait_state("reenter_service", 4'd3, 12);
        pulse_done();
        exp_write(32'h0, W_READY);
        tick(2);
        chk("pre_reset_state", responder_state, 4'd5);
        check_writes("pre_reset");
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        model_rounds = 16'd0;
        model_perr   = 1'b0;
        qkd_enable   = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);
        check_writes("reset_hold");

        // qkd_enable dropped in POLL_REQ goes straight to WRITE_OFF.
        fpga_write(F_IDLE);
        qkd_enable = 1'b1;
        tick(1);
        exp_write(32'h0, W_ON);
        tick(4);
        chk("poll_before_drop", responder_state, 4'd2);
        qkd_enable = 1'b0;
        tick(1);
        chk("poll_drop_state", responder_state, 4'd7);
        chk("poll_drop_data", bram_dina, W_OFF);
        exp_write(32'h0, W_OFF);
        tick(1);
        chk("poll_drop_off", responder_state, 4'd0);
        chk("final_rounds", round_count, model_rounds);
        tick(2);
        check_writes("poll_drop");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/a_bram_host_responder.md
# a_bram_host_responder

Host-side responder for the AXI manager BRAM state-word handshake. It drives port A of the manager BRAM, the port opposite the FPGA-side request/ready controller. The block announces QKD ON, polls the FPGA state word for requests, and hands each request to a local data-service stub. It then writes READY, waits for the FPGA to return to IDLE, and closes the round with an IDLE word. It replaces the PC software in loopback builds and in system simulation.

## Interface
- No parameters; all encodings and addresses come from the shared package.
- clk  in  1  system clock; also drives bram_clka
- rst  in  1  asynchronous, active-high reset
- qkd_enable  in  1  level; high = QKD session on
- service_req  out  1  level; high while a request is being serviced
- service_fields  out  6  latched request bits {sklen, qubit, EVrb, PArb, sk1, sk2}; 1 = REQUEST
- service_done  in  1  one-cycle pulse from the data-service stub
- bram_clka  out  1  = clk
- bram_addra  out  32  port A byte address
- bram_dina  out  64  port A write data
- bram_ena  out  1  constant 1
- bram_rsta  out  1  constant 0
- bram_wea  out  8  byte write enables
- bram_douta  in  64  port A read data, 1-cycle read latency
- round_count  out  16  completed rounds, wraps at 0xFFFF→0
- protocol_error  out  1  sticky illegal-word flag
- responder_state  out  4  current FSM state

## Operation
State word, bits [63:32] = 0:
- [31:28] on/off
- [27:24] sklen
- [23:20] qubit
- [19:16] EVrb
- [15:12] PArb
- [11:8] sk1
- [7:4] sk2
- [3:0] writer

FSM states and transitions:
- OFF(0): no write. On qkd_enable → WRITE_ON.
- WRITE_ON(1): write {ON, IDLE×6, WRITER_PC} to PC_STATE_ADDRESS. → POLL_REQ.
- POLL_REQ(2): read FPGA_STATE_ADDRESS. Go to SERVICE when the registered word has on/off = ON, writer = WRITER_KCU116 and at least one field = REQUEST. On that transition, latch service_fields (bit = field==REQUEST).
- SERVICE(3): service_req = 1. On service_done → WRITE_READY.
- WRITE_READY(4): write {ON, READY×6, WRITER_PC}. → POLL_IDLE.
- POLL_IDLE(5): wait until the FPGA word equals {ON, IDLE×6, WRITER_KCU116}. → WRITE_IDLE.
- WRITE_IDLE(6): write {ON, IDLE×6, WRITER_PC}; round_count += 1. → POLL_REQ.
- WRITE_OFF(7): write 64'h0 to PC_STATE_ADDRESS. → OFF.

Boundary conditions:
- qkd_enable low in states 1, 2, 4, 5 or 6 → next state is WRITE_OFF. A write already scheduled in the current cycle still completes.
- qkd_enable low in SERVICE is deferred until service_done, then → WRITE_OFF instead of WRITE_READY.
- In POLL_REQ, a word with ON and WRITER_KCU116 but any field outside {IDLE, REQUEST} sets protocol_error and the word is ignored.
- Words with any other writer, or with on/off ≠ ON, are ignored silently.
- service_done outside SERVICE is ignored.
- service_fields holds its value until the next latch.

## Timing
Reset values:
- state = OFF
- service_req = 0
- service_fields = 0
- round_count = 0
- protocol_error = 0
- bram_wea = 0
- bram_dina = 0
- bram_addra = FPGA_STATE_ADDRESS

Writes:
- Every write is a single cycle with bram_wea = 8'hFF, occurring in the WRITE_* state cycle.
- bram_wea, bram_dina and bram_addra are a Moore decode of the state register.
- Outside write states: wea = 0, dina = 0, addra = FPGA_STATE_ADDRESS.

Read path:
- bram_douta is registered once (dout_q) before any compare.
- On entry to POLL_REQ or POLL_IDLE, a 2-cycle settle counter masks dout_q, so no decision is made on stale data.
- Request latency: FPGA word committed at edge E → dout_q valid after E+2 → state changes at E+3. service_req is high from E+3.
- service_done at edge D → WRITE_READY at D+1 → READY word committed at D+2.
- Asynchronous reset mid-round returns to OFF immediately. No OFF word is written; the next session rewrites the ON word.

## Structure
- Shared package (qkd_bram_pkg) holds:
  - field encodings: ON_STATE = 4'h1, OFF_STATE = 4'h0, IDLE_STATE = 4'h0, REQUEST_STATE = 4'h1, READY_STATE = 4'h2
  - WRITER_PC = 4'hA, WRITER_KCU116 = 4'hB
  - PC_STATE_ADDRESS = 32'h0, FPGA_STATE_ADDRESS = 32'h8
  - NO_USE_BIT_WIDTH = 32
  - the responder state enum
- These constants are shared with the FPGA-side controller.
- One sub-module: a_bram_host_responder_fsm, holding the state register, next-state logic and settle counter. The top level holds dout_q, the latches, the counter and the BRAM output decode.

## Test plan
- Reset, then raise qkd_enable → one write of 64'h0000_0000_1000_000A at address 0x0, then polling of 0x8 with wea = 0.
- FPGA writes 0x1011_0000_B... with qubit = REQUEST and EVrb = REQUEST, value 0x1011_000B at 0x8 → service_req rises 3 cycles later with service_fields = 6'b011000.
- service_done pulse → READY word 0x1222_222A written at 0x0 two edges later. FPGA then writes 0x1000_000B → IDLE word 0x1000_000A written and round_count = 1.
- FPGA word 0x1031_000B (field = 3) → protocol_error = 1, no service_req; the flag stays set through later legal rounds.
- qkd_enable dropped during SERVICE → no write until service_done, then a 64'h0 write at 0x0 and state OFF.
- Preload round_count = 0xFFFF via 65535 rounds (or force) → the next round reads 0; asserting rst mid-POLL_IDLE returns all outputs to their reset values immediately.
